fsm_encaixotamento: RTL
=======================

// Module: fsm_encaixotamento
// PURPOSE
//  Downstream of the quality FSM. Counts approved-bottle pulses (INCREMENTA_DUZIA) into cases of
//  GARRAFAS_POR_CAIXA, requests case removal, and waits for an empty case to be positioned.
//  Buffers bottles arriving during a case exchange, stops the conveyor when that buffer is full,
//  and raises an alarm on a handshake timeout.
// PARAMETERS
//  GARRAFAS_POR_CAIXA  12    bottles per case; must be > PENDENTE_MAX
//  PENDENTE_MAX        3     bottles that may queue during a case exchange (>=1)
//  TIMEOUT_CICLOS      1000  max cycles spent in AGUARDA_* before ALARME
//  W_TOTAL             8     width of the case total counter
// PORTS
//  CLOCK              in   1        single clock, rising edge
//  RESET_N            in   1        asynchronous, active-low reset
//  INCREMENTA_DUZIA   in   1        1-cycle pulse: one bottle approved
//  CAIXA_RETIRADA     in   1        handler ack: full case removed
//  CAIXA_POSICIONADA  in   1        empty case in place
//  LIMPA_ALARME       in   1        operator clears ALARME
//  CONTAGEM           out  4        bottles in current case
//  PENDENTE           out  2        bottles queued during exchange
//  CAIXA_PRONTA       out  1        request: full case ready for removal
//  PARAR_ESTEIRA      out  1        stop upstream conveyor
//  ALARME             out  1        timeout alarm
//  ERRO_PERDA         out  1        sticky: pulse dropped while queue full
//  TOTAL_CAIXAS       out  W_TOTAL  cases removed, wraps to 0
// BEHAVIOUR
//  - Reset (RESET_N=0, async): state=ENCHENDO; all counters 0; all outputs 0.
//  - All outputs are registered or decoded from registered state only; inputs sampled at posedge.
//  - ENCHENDO: a pulse gives CONTAGEM+1. On the edge where CONTAGEM goes to GARRAFAS_POR_CAIXA:
//    state -> AGUARDA_RETIRADA and CAIXA_PRONTA=1 starting the next cycle. That is 1-cycle latency.
//  - AGUARDA_RETIRADA: CAIXA_PRONTA held high until CAIXA_RETIRADA is sampled.
//    On that edge: TOTAL_CAIXAS+1 (mod 2^W_TOTAL), CONTAGEM=0, state -> AGUARDA_NOVA.
//  - AGUARDA_NOVA: CAIXA_PRONTA=0. When CAIXA_POSICIONADA is sampled:
//    CONTAGEM=PENDENTE (+1 if a pulse arrives the same cycle), PENDENTE=0, state -> ENCHENDO.
//  - Outside ENCHENDO, pulses increment PENDENTE.
//    A pulse with PENDENTE==PENDENTE_MAX is dropped and sets ERRO_PERDA (cleared only by reset).
//  - PARAR_ESTEIRA = (PENDENTE==PENDENTE_MAX) | (state==ALARME).
//  - CAIXA_RETIRADA in ENCHENDO/AGUARDA_NOVA and CAIXA_POSICIONADA outside AGUARDA_NOVA are ignored.
//  - Timeout counter: cleared on every state change.
//    It increments each cycle in AGUARDA_RETIRADA/AGUARDA_NOVA.
//    When it reaches TIMEOUT_CICLOS-1 with no exit condition: state -> ALARME.
//    An exit condition on that same edge wins over the timeout.
//  - ALARME: ALARME=1, CAIXA_PRONTA=0; the case in place is discarded (CONTAGEM=0, TOTAL unchanged).
//    Pulses queue into PENDENTE or are dropped as above.
//    LIMPA_ALARME -> AGUARDA_NOVA (timeout restarts).
//  - Reset mid-exchange: pending bottles and the in-progress case are lost; no flags are preserved.
// TESTING
//  1. 12 pulses spaced 3 cycles apart -> CONTAGEM 1..12; CAIXA_PRONTA=1 the cycle after the 12th; TOTAL_CAIXAS=0.
//  2. Continue 1: CAIXA_RETIRADA after 5 cycles -> TOTAL_CAIXAS=1, CAIXA_PRONTA=0; CAIXA_POSICIONADA -> ENCHENDO, CONTAGEM=0.
//  3. During the exchange, 2 pulses then CAIXA_POSICIONADA together with a 3rd pulse -> CONTAGEM=3, PENDENTE=0.
//  4. 4 pulses during the exchange -> PENDENTE=3, PARAR_ESTEIRA=1 after the 3rd; 4th dropped, ERRO_PERDA=1.
//  5. Withhold CAIXA_RETIRADA for 1000 cycles -> ALARME=1, PARAR_ESTEIRA=1; LIMPA_ALARME -> ALARME=0, state AGUARDA_NOVA.
//  6. RESET_N low mid-AGUARDA_RETIRADA (async, off-edge) -> all outputs 0 immediately; 256 cases -> TOTAL_CAIXAS wraps to 0.

Source files
------------

// File: rtl/fsm_encaixotamento.sv
// Case-packing controller: counts approved bottles into cases, handshakes case removal and
// placement, queues bottles arriving during an exchange and alarms on a stalled handshake.
module fsm_encaixotamento #(
   parameter int GARRAFAS_POR_CAIXA = 12,
   parameter int PENDENTE_MAX       = 3,
   parameter int TIMEOUT_CICLOS     = 1000,
   parameter int W_TOTAL            = 8
) (
   input  logic               CLOCK,
   input  logic               RESET_N,
   input  logic               INCREMENTA_DUZIA,
   input  logic               CAIXA_RETIRADA,
   input  logic               CAIXA_POSICIONADA,
   input  logic               LIMPA_ALARME,
   output logic [3:0]         CONTAGEM,
   output logic [1:0]         PENDENTE,
   output logic               CAIXA_PRONTA,
   output logic               PARAR_ESTEIRA,
   output logic               ALARME,
   output logic               ERRO_PERDA,
   output logic [W_TOTAL-1:0] TOTAL_CAIXAS
);

   localparam int TW = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
   localparam logic [3:0]    CHEIA = 4'(GARRAFAS_POR_CAIXA);
   localparam logic [1:0]    PMAX  = 2'(PENDENTE_MAX);
   localparam logic [TW-1:0] T_LIM = TW'(TIMEOUT_CICLOS - 1);

   typedef enum logic [1:0] {
      ENCHENDO,
      AGUARDA_RETIRADA,
      AGUARDA_NOVA,
      EM_ALARME
   } estado_t;

   estado_t              estado, estado_nxt;
   logic [3:0]           contagem, contagem_nxt;
   logic [1:0]           pendente, pendente_nxt;
   logic [W_TOTAL-1:0]   total, total_nxt;
   logic [TW-1:0]        timer, timer_nxt;
   logic                 erro, erro_nxt;

   always_comb begin
      estado_nxt   = estado;
      contagem_nxt = contagem;
      pendente_nxt = pendente;
      total_nxt    = total;
      timer_nxt    = timer;
      erro_nxt     = erro;

      // Any bottle arriving while no case is being filled goes to the holding queue.
      if (estado != ENCHENDO && INCREMENTA_DUZIA) begin
         if (pendente == PMAX) erro_nxt = 1'b1;
         else                  pendente_nxt = pendente + 2'd1;
      end

      case (estado)
         ENCHENDO: begin
            if (INCREMENTA_DUZIA) begin
               contagem_nxt = contagem + 4'd1;
               if (contagem_nxt == CHEIA) estado_nxt = AGUARDA_RETIRADA;
            end
         end
         AGUARDA_RETIRADA: begin
            if (CAIXA_RETIRADA) begin
               total_nxt    = total + W_TOTAL'(1);
               contagem_nxt = '0;
               estado_nxt   = AGUARDA_NOVA;
            end else if (timer == T_LIM) begin
               contagem_nxt = '0;
               estado_nxt   = EM_ALARME;
            end else begin
               timer_nxt = timer + TW'(1);
            end
         end
         AGUARDA_NOVA: begin
            if (CAIXA_POSICIONADA) begin
               // The queued bottles and a coincident pulse all start the new case.
               contagem_nxt = {2'b00, pendente} + {3'b000, INCREMENTA_DUZIA};
               pendente_nxt = '0;
               erro_nxt     = erro;
               estado_nxt   = (contagem_nxt == CHEIA) ? AGUARDA_RETIRADA : ENCHENDO;
            end else if (timer == T_LIM) begin
               estado_nxt = EM_ALARME;
            end else begin
               timer_nxt = timer + TW'(1);
            end
         end
         EM_ALARME: begin
            contagem_nxt = '0;
            if (LIMPA_ALARME) estado_nxt = AGUARDA_NOVA;
         end
      endcase

      if (estado_nxt != estado) timer_nxt = '0;
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         estado        <= ENCHENDO;
         contagem      <= '0;
         pendente      <= '0;
         total         <= '0;
         timer         <= '0;
         erro          <= 1'b0;
         CAIXA_PRONTA  <= 1'b0;
         PARAR_ESTEIRA <= 1'b0;
         ALARME        <= 1'b0;
      end else begin
         estado        <= estado_nxt;
         contagem      <= contagem_nxt;
         pendente      <= pendente_nxt;
         total         <= total_nxt;
         timer         <= timer_nxt;
         erro          <= erro_nxt;
         CAIXA_PRONTA  <= (estado_nxt == AGUARDA_RETIRADA);
         PARAR_ESTEIRA <= (pendente_nxt == PMAX) || (estado_nxt == EM_ALARME);
         ALARME        <= (estado_nxt == EM_ALARME);
      end
   end

   assign CONTAGEM     = contagem;
   assign PENDENTE     = pendente;
   assign ERRO_PERDA   = erro;
   assign TOTAL_CAIXAS = total;

endmodule
